// File: rtl/iob_uart_bridge.sv
// UART-to-IOb bridge: 8N1 command frames in, one IOb access per frame,
// serial response out (0xAA write ack, 4 read bytes, or 0xEE on bad command).
module iob_uart_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DIV_W  = 16
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic [DIV_W-1:0]    bit_duration_i,
    input  logic                rxd_i,
    output logic                txd_o,
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    output logic                busy_o,
    output logic                frame_err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_BUS, S_WAIT_R, S_TX
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_t;

    state_t             r_state, w_nst;
    rx_t                r_rx_st, w_rx_nst;

    logic               r_rx_s1, r_rx_s2, r_rx_d;
    logic [DIV_W-1:0]   r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_sh;
    logic               r_ferr;

    logic               r_wr;
    logic [1:0]         r_bcnt;
    logic [31:0]        r_addr;
    logic [DATA_W-1:0]  r_wdata;

    logic [31:0]        r_tx_buf;
    logic [2:0]         r_tx_left;
    logic [3:0]         r_tx_bit;
    logic [DIV_W-1:0]   r_tx_cnt;
    logic               r_txd;

    logic               w_rx_en, w_rx_tick, w_tx_tick;
    logic               w_rx_start, w_rx_done, w_rx_ferr;
    logic               w_cmd_ok;
    logic               w_tx_load;
    logic [31:0]        w_tx_data;
    logic [2:0]         w_tx_n;
    logic [DIV_W-1:0]   w_half, w_full;

    assign w_full    = bit_duration_i - DIV_W'(1);
    assign w_half    = {1'b0, bit_duration_i[DIV_W-1:1]} - DIV_W'(1);
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_tx_tick = (r_tx_cnt == '0);
    assign w_cmd_ok  = (r_rx_sh == 8'h01) || (r_rx_sh == 8'h02);
    // Receiver only listens while a command is being collected.
    assign w_rx_en   = (r_state == S_IDLE) || (r_state == S_CMD) ||
                       (r_state == S_ADDR) || (r_state == S_DATA);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rxd_i;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    always_comb begin
        w_rx_nst   = r_rx_st;
        w_rx_start = 1'b0;
        w_rx_done  = 1'b0;
        w_rx_ferr  = 1'b0;
        if (!w_rx_en) begin
            w_rx_nst = RX_IDLE;
        end else begin
            unique case (r_rx_st)
                RX_IDLE: if (r_rx_d && !r_rx_s2) w_rx_nst = RX_START;
                RX_START: begin
                    if (w_rx_tick) begin
                        if (r_rx_s2) begin
                            w_rx_nst = RX_IDLE;
                        end else begin
                            w_rx_nst   = RX_DATA;
                            w_rx_start = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nst = RX_STOP;
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        w_rx_nst  = RX_IDLE;
                        w_rx_done = r_rx_s2;
                        w_rx_ferr = !r_rx_s2;
                    end
                end
                default: w_rx_nst = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rx_st  <= RX_IDLE;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
            r_ferr   <= 1'b0;
        end else begin
            r_rx_st <= w_rx_nst;
            r_ferr  <= w_rx_ferr;
            if (r_rx_st == RX_IDLE) begin
                r_rx_cnt <= w_half;
                r_rx_bit <= '0;
            end else if (w_rx_tick) begin
                r_rx_cnt <= w_full;
            end else begin
                r_rx_cnt <= r_rx_cnt - DIV_W'(1);
            end
            if (r_rx_st == RX_DATA && w_rx_tick) begin
                r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
        end
    end

    always_comb begin
        w_nst     = r_state;
        w_tx_load = 1'b0;
        w_tx_data = '0;
        w_tx_n    = 3'd1;
        unique case (r_state)
            S_IDLE: if (w_rx_start) w_nst = S_CMD;
            S_CMD: begin
                if (w_rx_ferr) begin
                    w_nst = S_IDLE;
                end else if (w_rx_done) begin
                    w_nst = w_cmd_ok ? S_ADDR : S_TX;
                    if (!w_cmd_ok) begin
                        w_tx_load = 1'b1;
                        w_tx_data = 32'hEE;
                    end
                end
            end
            S_ADDR: begin
                if (w_rx_ferr) begin
                    w_nst = S_IDLE;
                end else if (w_rx_done && r_bcnt == 2'd3) begin
                    w_nst = r_wr ? S_DATA : S_BUS;
                end
            end
            S_DATA: begin
                if (w_rx_ferr) begin
                    w_nst = S_IDLE;
                end else if (w_rx_done && r_bcnt == 2'd3) begin
                    w_nst = S_BUS;
                end
            end
            S_BUS: begin
                if (iob_ready_i) begin
                    // Read data may arrive together with the accept.
                    if (r_wr) begin
                        w_nst     = S_TX;
                        w_tx_load = 1'b1;
                        w_tx_data = 32'hAA;
                    end else if (iob_rvalid_i) begin
                        w_nst     = S_TX;
                        w_tx_load = 1'b1;
                        w_tx_data = iob_rdata_i;
                        w_tx_n    = 3'd4;
                    end else begin
                        w_nst = S_WAIT_R;
                    end
                end
            end
            S_WAIT_R: begin
                if (iob_rvalid_i) begin
                    w_nst     = S_TX;
                    w_tx_load = 1'b1;
                    w_tx_data = iob_rdata_i;
                    w_tx_n    = 3'd4;
                end
            end
            S_TX: begin
                if (w_tx_tick && r_tx_bit == 4'd9 && r_tx_left == 3'd1) begin
                    w_nst = S_IDLE;
                end
            end
            default: w_nst = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_bcnt  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_nst;
            if (r_state == S_CMD && w_rx_done) begin
                r_wr   <= (r_rx_sh == 8'h01);
                r_bcnt <= '0;
            end
            if (r_state == S_ADDR && w_rx_done) begin
                r_addr[{r_bcnt, 3'b000} +: 8] <= r_rx_sh;
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (r_state == S_DATA && w_rx_done) begin
                r_wdata[{r_bcnt, 3'b000} +: 8] <= r_rx_sh;
                r_bcnt <= r_bcnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_tx_buf  <= '0;
            r_tx_left <= '0;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
            r_txd     <= 1'b1;
        end else if (w_tx_load) begin
            r_tx_buf  <= w_tx_data;
            r_tx_left <= w_tx_n;
            r_tx_bit  <= '0;
            r_tx_cnt  <= w_full;
            r_txd     <= 1'b0;
        end else if (r_state == S_TX) begin
            if (w_tx_tick) begin
                r_tx_cnt <= w_full;
                if (r_tx_bit == 4'd9) begin
                    if (r_tx_left > 3'd1) begin
                        r_tx_buf  <= r_tx_buf >> 8;
                        r_tx_left <= r_tx_left - 3'd1;
                        r_tx_bit  <= '0;
                        r_txd     <= 1'b0;
                    end else begin
                        r_txd <= 1'b1;
                    end
                end else begin
                    r_tx_bit <= r_tx_bit + 4'd1;
                    r_txd    <= (r_tx_bit == 4'd8) ? 1'b1
                                                   : r_tx_buf[r_tx_bit[2:0]];
                end
            end else begin
                r_tx_cnt <= r_tx_cnt - DIV_W'(1);
            end
        end
    end

    assign txd_o       = r_txd;
    assign iob_valid_o = (r_state == S_BUS);
    assign iob_addr_o  = r_addr[ADDR_W-1:0];
    assign iob_wdata_o = r_wdata;
    assign iob_wstrb_o = (iob_valid_o && r_wr) ? '1 : '0;
    assign busy_o      = (r_state != S_IDLE);
    assign frame_err_o = r_ferr;

endmodule

// File: doc/iob_uart_bridge.md
# iob_uart_bridge

UART-to-IOb bus bridge: the initiator-side counterpart of the UART peripheral. It receives 8N1 command frames on a serial line, turns each frame into a single IOb bus transaction as initiator, and returns a serial response. It lets an external host or debugger read and write any IOb-mapped register, including the UART peripheral's own CSRs, with no CPU involvement.

## Interface
- ADDR_W, 32: IOb address width; the command frame always carries 4 address bytes, and only the low ADDR_W bits are used.
- DATA_W, 32: IOb data width; fixed at 32, so every frame carries 4 data bytes.
- DIV_W, 16: width of the bit-duration input.
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous active-low reset.
- bit_duration_i  in  DIV_W  clock cycles per serial bit; minimum legal value is 8; held static while busy_o=1.
- rxd_i  in  1  serial input, idle high.
- txd_o  out  1  serial output, idle high.
- iob_valid_o  out  1  IOb request valid.
- iob_addr_o  out  ADDR_W  request address.
- iob_wdata_o  out  DATA_W  write data.
- iob_wstrb_o  out  DATA_W/8  write strobes; 0 means read.
- iob_ready_i  in  1  request accepted.
- iob_rvalid_i  in  1  read data valid.
- iob_rdata_i  in  DATA_W  read data.
- busy_o  out  1  high from the first command byte until the last response stop bit.
- frame_err_o  out  1  one-cycle pulse when a received byte has stop bit = 0.

## Operation
- The receiver passes rxd_i through a 2-flop synchronizer. A falling edge starts a byte.
  - At bit_duration_i/2 the start bit is re-checked; if it is high, the event is a glitch and the receiver returns to idle.
  - Data bits are then sampled every bit_duration_i cycles, LSB first, followed by the stop bit.
- Byte framing error (stop bit = 0):
  - frame_err_o pulses for one cycle.
  - The partially received command is discarded and the FSM returns to IDLE.
  - No response is sent.
- Command frame: CMD, then A0..A3 (little-endian), then D0..D3 (little-endian) only when CMD = 0x01.
  - 0x01 = write.
  - 0x02 = read.
  - Any other value: send 0xEE and do not issue a bus access.
- FSM states:
  - IDLE → CMD on the first received byte.
  - CMD → ADDR. The byte counter counts 0..3 in ADDR and again in DATA.
  - ADDR → DATA for a write, or ADDR → BUS for a read.
  - DATA → BUS.
  - BUS → WAIT_R for a read, or BUS → TX for a write.
  - WAIT_R → TX.
  - TX → IDLE.
- BUS state:
  - iob_valid_o=1 with address and data stable.
  - For a write, iob_wstrb_o=4'hF; for a read, 0.
  - Leave BUS in the cycle where iob_ready_i=1 is sampled.
- WAIT_R state: capture iob_rdata_i in the cycle where iob_rvalid_i=1. iob_rvalid_i in the same cycle as iob_ready_i is legal and is captured.
- TX responses:
  - Write: one byte, 0xAA.
  - Read: 4 bytes, LSB first.
  - Error: one byte, 0xEE.
  - Each byte is framed as start bit, 8 data bits, stop bit, one bit_duration_i each. Bytes are sent back-to-back.
- Bytes arriving on rxd_i during BUS/WAIT_R/TX are ignored; the receiver stays idle until the FSM returns to IDLE.

## Timing
- Reset values: txd_o=1, iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, busy_o=0, frame_err_o=0, FSM=IDLE.
- Reset asserted mid-operation aborts everything immediately and forces all outputs to their reset values. Any IOb request in progress is dropped.
- iob_valid_o rises 1 cycle after the stop-bit sample of the last frame byte.
- iob_valid_o falls in the cycle after iob_ready_i=1 is sampled; it is held high for as long as iob_ready_i=0.
- The first TX start bit (txd_o=0) begins 1 cycle after:
  - the iob_ready_i acceptance, for a write;
  - the iob_rvalid_i capture, for a read;
  - the CMD byte's stop-bit sample, for an illegal command.
- busy_o falls 1 cycle after the last stop bit completes.
- The bit counter is DIV_W bits wide and reloads to bit_duration_i-1; there is no cumulative drift across bytes.

## Test plan
- Write command, bit_duration_i=16, frame 01 10 00 00 00 EF BE AD DE, iob_ready_i high immediately → exactly one request: addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then txd_o emits 0xAA.
- Read command, frame 02 04 00 00 00, iob_ready_i delayed 5 cycles, iob_rvalid_i with rdata 0x12345678 after 3 more cycles → iob_valid_o held for 6 cycles; txd_o emits 78 56 34 12.
- Command byte 0x7F → no iob_valid_o; txd_o emits 0xEE; busy_o returns to 0.
- Stop bit forced to 0 on address byte A1 → frame_err_o pulses once; no bus access and no TX; a following valid read completes normally.
- 3-cycle low glitch on rxd_i with bit_duration_i=16 → no byte received, busy_o stays 0.
- arst_n_i asserted while in WAIT_R → all outputs at reset values; a subsequent write frame completes correctly.
